// File: rtl/rf_wb_sched.sv
// Writeback scheduler and scoreboard for a 32x64 register file: LSU/ALU write-port arbitration,
// per-register busy tracking and RAW/WAW issue stall. Optional counters: RF_WB_SCHED_PERF_EN.
module rf_wb_sched #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_wen,
  output logic            issue_ready,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy_vec,
  output logic            sb_err
`ifdef RF_WB_SCHED_PERF_EN
  ,
  output logic [63:0]     stall_cnt,
  output logic [63:0]     conflict_cnt
`endif
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            wb_acc;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            issue_fire;

  // LSU has fixed priority; a stalled ALU result is held by its source.
  assign lsu_ready = 1'b1;
  assign alu_ready = ~lsu_valid;
  assign wb_acc    = lsu_valid | alu_valid;
  assign wb_rd     = lsu_valid ? lsu_rd   : alu_rd;
  assign wb_data   = lsu_valid ? lsu_data : alu_data;

  assign issue_ready = ~busy_q[issue_rs1] & ~busy_q[issue_rs2] & ~(issue_wen & busy_q[issue_rd]);
  assign issue_fire  = issue_valid & issue_ready & issue_wen & (issue_rd != '0);
  assign busy_vec    = busy_q;

  // Clear lands with the register file write; a same-index set takes precedence.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen) begin
      busy_d[rf_waddr] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q   <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      sb_err   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      rf_wen <= wb_acc & (wb_rd != '0);
      if (wb_acc) begin
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end
      if (wb_acc && (wb_rd != '0) && !busy_q[wb_rd]) begin
        sb_err <= 1'b1;
      end
    end
  end

`ifdef RF_WB_SCHED_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (issue_valid && !issue_ready) begin
        stall_cnt <= stall_cnt + 64'd1;
      end
      if (alu_valid && lsu_valid) begin
        conflict_cnt <= conflict_cnt + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_sched.sv
// Scoreboard bench for rf_wb_sched: expected register file writes are queued when a writeback
// is driven and popped when rf_wen is observed.
module tb_rf_wb_sched;
  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            issue_valid, issue_wen, issue_ready;
  logic [AW-1:0]   issue_rs1, issue_rs2, issue_rd;
  logic            alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0]   alu_rd, lsu_rd;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] busy_vec;
  logic            sb_err;
`ifdef RF_WB_SCHED_PERF_EN
  logic [63:0]     stall_cnt, conflict_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [AW+XLEN-1:0] exp_q[$];

  always #5 clock = ~clock;

  rf_wb_sched #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_rd     (issue_rd),
    .issue_wen    (issue_wen),
    .issue_ready  (issue_ready),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .lsu_valid    (lsu_valid),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .lsu_ready    (lsu_ready),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy_vec     (busy_vec),
    .sb_err       (sb_err)
`ifdef RF_WB_SCHED_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                             input logic [AW-1:0] rd, input logic wen);
    issue_valid = 1'b1;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    issue_rd    = rd;
    issue_wen   = wen;
    #1;
  endtask

  // Scoreboard: every observed write must match the oldest queued expectation.
  always @(negedge clock) begin
    if (rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_wen", 64'(rf_waddr), 64'hFFFF);
      end else begin
        logic [AW+XLEN-1:0] e;
        e = exp_q.pop_front();
        check("wb_addr", 64'(rf_waddr), 64'(e[AW+XLEN-1:XLEN]));
        check("wb_data", rf_wdata, e[XLEN-1:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; issue_wen = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 64'(busy_vec), 64'h0);
    check("rst_wen", 64'(rf_wen), 64'h0);
    check("rst_waddr", 64'(rf_waddr), 64'h0);
    check("rst_wdata", rf_wdata, 64'h0);
    check("rst_err", 64'(sb_err), 64'h0);

    // Issue rd=5, then a RAW-dependent issue stalls.
    drive_issue(5'd0, 5'd0, 5'd5, 1'b1);
    check("issue_rd5_ready", 64'(issue_ready), 64'h1);
    tick();
    issue_valid = 1'b0;
    check("busy_rd5", 64'(busy_vec), 64'h20);
    drive_issue(5'd5, 5'd0, 5'd0, 1'b0);
    check("raw_stall", 64'(issue_ready), 64'h0);
    issue_valid = 1'b0;

    // ALU writeback to r5: write in N+1, still busy then, free in N+2.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF;
    #1;
    check("alu_ready_solo", 64'(alu_ready), 64'h1);
    exp_q.push_back({5'd5, 64'hDEAD_BEEF});
    tick();
    alu_valid = 1'b0;
    #1;
    check("wen_n1", 64'(rf_wen), 64'h1);
    check("busy_n1", 64'(busy_vec), 64'h20);
    check("raw_n1", 64'(issue_ready), 64'h0);
    tick();
    check("busy_n2", 64'(busy_vec), 64'h0);
    check("raw_n2", 64'(issue_ready), 64'h1);
    check("wen_n2", 64'(rf_wen), 64'h0);

    // Make r3 and r4 busy, then collide ALU and LSU writebacks.
    drive_issue(5'd0, 5'd0, 5'd3, 1'b1);
    tick();
    drive_issue(5'd0, 5'd0, 5'd4, 1'b1);
    tick();
    issue_valid = 1'b0;
    check("busy_34", 64'(busy_vec), 64'h18);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h1111_2222_3333_4444;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    check("alu_ready_conflict", 64'(alu_ready), 64'h0);
    check("lsu_ready", 64'(lsu_ready), 64'h1);
    exp_q.push_back({5'd4, 64'hAAAA_BBBB_CCCC_DDDD});
    tick();
    lsu_valid = 1'b0;
    #1;
    check("alu_ready_after", 64'(alu_ready), 64'h1);
    check("wen_lsu", 64'(rf_wen), 64'h1);
    exp_q.push_back({5'd3, 64'h1111_2222_3333_4444});
    tick();
    alu_valid = 1'b0;
    check("wen_alu_b2b", 64'(rf_wen), 64'h1);
    check("waddr_alu_b2b", 64'(rf_waddr), 64'h3);
    tick();
    tick();
    check("busy_34_clear", 64'(busy_vec), 64'h0);
    check("waddr_hold", 64'(rf_waddr), 64'h3);
    check("wdata_hold", rf_wdata, 64'h1111_2222_3333_4444);

    // WAW stall on busy r7; non-writing instruction with same fields may issue.
    drive_issue(5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    drive_issue(5'd0, 5'd0, 5'd7, 1'b1);
    check("waw_stall", 64'(issue_ready), 64'h0);
    drive_issue(5'd0, 5'd0, 5'd7, 1'b0);
    check("waw_nowen", 64'(issue_ready), 64'h1);
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h7;
    exp_q.push_back({5'd7, 64'h7});
    tick();
    alu_valid = 1'b0;
    tick();
    check("busy_7_clear", 64'(busy_vec), 64'h0);
    check("err_clean", 64'(sb_err), 64'h0);

    // Writeback to x0 is accepted but never written.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h1234;
    #1;
    check("alu_ready_x0", 64'(alu_ready), 64'h1);
    tick();
    alu_valid = 1'b0;
    check("wen_x0", 64'(rf_wen), 64'h0);
    check("err_x0", 64'(sb_err), 64'h0);

    // Writeback to non-busy r9: written anyway, sb_err sticky.
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 64'h99;
    exp_q.push_back({5'd9, 64'h99});
    tick();
    lsu_valid = 1'b0;
    check("wen_r9", 64'(rf_wen), 64'h1);
    check("err_set", 64'(sb_err), 64'h1);
    tick();
    tick();
    check("err_sticky", 64'(sb_err), 64'h1);
`ifdef RF_WB_SCHED_PERF_EN
    check("conflict_cnt", conflict_cnt, 64'h1);
`endif

    // Reset in the cycle after an accepted writeback.
    drive_issue(5'd0, 5'd0, 5'd12, 1'b1);
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'hA;
    exp_q.push_back({5'd10, 64'hA});
    tick();
    alu_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_wen", 64'(rf_wen), 64'h0);
    check("rst2_busy", 64'(busy_vec), 64'h0);
    check("rst2_err", 64'(sb_err), 64'h0);
`ifdef RF_WB_SCHED_PERF_EN
    check("rst2_stall", stall_cnt, 64'h0);
    check("rst2_conflict", conflict_cnt, 64'h0);
`endif
    tick();
    tick();
    check("rst2_wen_quiet", 64'(rf_wen), 64'h0);
    check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
